// File: rtl/spi_axi_pkg.sv
// Shared definitions for the two-master register-port arbiter: state encoding and
// default bus widths.
package spi_axi_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;

  // Read latency is limited to 1..4, so a 2-bit down-counter covers the wait.
  localparam int unsigned MAX_RD_LAT = 4;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_ACK
  } state_e;

endpackage

// File: rtl/spi_axi_rr_arb2.sv
// Two-way round-robin chooser. The pointer remembers the last granted master and is
// advanced only when the caller commits a grant with update.
module spi_axi_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant
);

  logic last_q;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_q;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  // Reset points at m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/spi_axi_reg_arb.sv
// Arbitrates two request/ack masters onto one shared register port with separate
// write and read strobes; reads wait RD_LAT cycles before the data is captured.
module spi_axi_reg_arb
  import spi_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              busy
);

  state_e             state_q, state_d;
  logic               gnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  rdata0_q, rdata1_q;

  logic               arb_grant;
  logic               arb_update;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               rd_capture;

  assign arb_update = (state_q == S_IDLE) && (m0_req || m1_req);

  spi_axi_rr_arb2 u_rr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (m0_req),
    .req1   (m1_req),
    .update (arb_update),
    .grant  (arb_grant)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (arb_grant) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = we_q ? S_ACK : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are frozen at grant; later master-side changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (arb_update) begin
      gnt_q   <= arb_grant;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Loaded with RD_LAT-1 while issuing so the wait spans exactly RD_LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      cnt_q <= CNT_W'(RD_LAT - 1);
    end else if ((state_q == S_RD_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rd_capture = (state_q == S_RD_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rd_capture) begin
      if (gnt_q) begin
        rdata1_q <= reg_rd_data;
      end else begin
        rdata0_q <= reg_rd_data;
      end
    end
  end

  assign reg_wr_en   = (state_q == S_ISSUE) && we_q;
  assign reg_rd_en   = (state_q == S_ISSUE) && !we_q;
  assign reg_wr_addr = addr_q;
  assign reg_rd_addr = addr_q;
  assign reg_wr_data = wdata_q;
  assign m0_ack      = (state_q == S_ACK) && !gnt_q;
  assign m1_ack      = (state_q == S_ACK) && gnt_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign busy        = (state_q != S_IDLE);

  a_one_strobe : assert property (@(posedge clk) disable iff (!rst_n)
    !(reg_wr_en && reg_rd_en));
  a_one_ack : assert property (@(posedge clk) disable iff (!rst_n)
    !(m0_ack && m1_ack));

endmodule

// File: tb/tb_spi_axi_reg_arb.sv
// Randomized bench for spi_axi_reg_arb: a transaction-level model predicts, per cycle,
// strobes, acks, busy, latched port values and read data from the latency rules.
module tb_spi_axi_reg_arb;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] reg_wr_addr, reg_rd_addr;
  logic [DW-1:0] reg_wr_data, reg_rd_data;
  logic          reg_wr_en, reg_rd_en, busy;

  always #5 clk = ~clk;

  spi_axi_reg_arb #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (req[0]),
    .m0_we       (we[0]),
    .m0_addr     (addr[0]),
    .m0_wdata    (wdata[0]),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m1_req      (req[1]),
    .m1_we       (we[1]),
    .m1_addr     (addr[1]),
    .m1_wdata    (wdata[1]),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one transaction record, described by grant cycle and derived ack cycle.
  bit            last_gnt;
  int            free_cyc;
  bit            act;
  int            t_g, t_ack;
  bit            t_m, t_we;
  logic [DW-1:0] t_rdv;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] exp_rdata [2];
  bit            pending [2];
  bit            inflight [2];
  bit            hold [2];
  bit            rand_mode;
  int            ack_log [$];
  int            ghost_cyc;
  logic [DW-1:0] ghost_val;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    last_gnt  = 1'b1;
    free_cyc  = 0;
    act       = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    for (int m = 0; m < 2; m++) begin
      exp_rdata[m] = '0;
      pending[m]   = 1'b0;
      inflight[m]  = 1'b0;
      hold[m]      = 1'b0;
      req[m]       = 1'b0;
    end
  endtask

  task automatic start_req(input int m, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    req[m]     = 1'b1;
    we[m]      = w;
    addr[m]    = a;
    wdata[m]   = d;
    pending[m] = 1'b1;
  endtask

  task automatic cycle_begin();
    bit strobe_now, ack_now;
    @(negedge clk);
    cyc++;
    if (act && !t_we && cyc == t_g + 1 + int'(LAT)) reg_rd_data = t_rdv;
    else if (cyc == ghost_cyc)                     reg_rd_data = ghost_val;
    else                                           reg_rd_data = $urandom();
    if (act && !t_we && cyc == t_ack) exp_rdata[t_m] = t_rdv;
    strobe_now = act && (cyc == t_g + 1);
    ack_now    = act && (cyc == t_ack);
    check_eq("wr_en", 32'(reg_wr_en), 32'(strobe_now && t_we));
    check_eq("rd_en", 32'(reg_rd_en), 32'(strobe_now && !t_we));
    check_eq("m0_ack", 32'(m0_ack), 32'(ack_now && !t_m));
    check_eq("m1_ack", 32'(m1_ack), 32'(ack_now && t_m));
    check_eq("busy", 32'(busy), 32'(act && cyc > t_g && cyc <= t_ack));
    check_eq("wr_addr", 32'(reg_wr_addr), 32'(exp_addr));
    check_eq("rd_addr", 32'(reg_rd_addr), 32'(exp_addr));
    check_eq("wr_data", reg_wr_data, exp_wdata);
    check_eq("m0_rdata", m0_rdata, exp_rdata[0]);
    check_eq("m1_rdata", m1_rdata, exp_rdata[1]);
    if (m0_ack) ack_log.push_back(0);
    if (m1_ack) ack_log.push_back(1);
    if (ack_now) begin
      inflight[t_m] = 1'b0;
      if (hold[t_m]) begin
        start_req(int'(t_m), 1'($urandom()), AW'($urandom()), $urandom());
      end else begin
        req[t_m]     = 1'b0;
        pending[t_m] = 1'b0;
      end
    end
  endtask

  task automatic drive_random();
    for (int m = 0; m < 2; m++) begin
      if (!pending[m]) begin
        if ($urandom_range(3) == 0) begin
          start_req(m, 1'($urandom()), AW'($urandom()), $urandom());
          hold[m] = ($urandom_range(3) == 0);
        end
      end else if (inflight[m]) begin
        if ($urandom_range(3) == 0) addr[m] = AW'($urandom());
        if ($urandom_range(3) == 0) wdata[m] = $urandom();
        if ($urandom_range(5) == 0) we[m] = ~we[m];
        if ($urandom_range(7) == 0) req[m] = 1'b0;
      end
    end
  endtask

  // Grant decision on the inputs the DUT will sample at the coming edge.
  task automatic cycle_end();
    bit w;
    if (rst_n && cyc >= free_cyc && (req[0] || req[1])) begin
      w         = (req[0] && req[1]) ? !last_gnt : req[1];
      last_gnt  = w;
      act       = 1'b1;
      t_g       = cyc;
      t_m       = w;
      t_we      = we[w];
      exp_addr  = addr[w];
      exp_wdata = wdata[w];
      t_ack     = cyc + 2 + (t_we ? 0 : int'(LAT));
      t_rdv     = $urandom();
      free_cyc  = t_ack + 1;
      inflight[w] = 1'b1;
    end
  endtask

  task automatic step();
    cycle_begin();
    if (rand_mode) drive_random();
    cycle_end();
  endtask

  task automatic drain();
    int n = 0;
    while ((pending[0] || pending[1] || cyc < free_cyc) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check_eq("drain_timeout", 32'(n), 32'd0);
  endtask

  // Called just after a cycle_begin; checks the asynchronous clear, then releases.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check_eq("rst_rd_en", 32'(reg_rd_en), 32'd0);
    check_eq("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    check_eq("rst_addrs", 32'({reg_wr_addr, reg_rd_addr}), 32'd0);
    check_eq("rst_wdata", reg_wr_data, 32'd0);
    check_eq("rst_rdata0", m0_rdata, 32'd0);
    check_eq("rst_rdata1", m1_rdata, 32'd0);
    model_reset();
    cycle_begin();
    cycle_begin();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b1;
    reg_rd_data = '0;
    ghost_cyc   = -1;
    ghost_val   = '0;
    rand_mode   = 1'b0;
    for (int m = 0; m < 2; m++) begin
      we[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    model_reset();
    #2;
    cycle_begin();
    pulse_reset();

    // Single write from m0.
    ack_log.delete();
    cycle_begin();
    start_req(0, 1'b1, 12'h123, 32'hDEADBEEF);
    cycle_end();
    drain();
    check_eq("wr_ack_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) check_eq("wr_ack_who", 32'(ack_log[0]), 32'd0);

    // Single read from m1 with a known return value.
    ack_log.delete();
    cycle_begin();
    start_req(1, 1'b0, 12'h0A5, 32'h0);
    cycle_end();
    t_rdv = 32'h12345678;
    drain();
    check_eq("rd_m1_rdata", m1_rdata, 32'h12345678);
    check_eq("rd_m0_rdata", m0_rdata, 32'h0);
    check_eq("rd_ack_count", 32'(ack_log.size()), 32'd1);

    // Tie straight after reset, both held: grants must alternate starting with m0.
    cycle_begin();
    pulse_reset();
    ack_log.delete();
    cycle_begin();
    start_req(0, 1'b1, 12'h010, $urandom());
    start_req(1, 1'b0, 12'h020, $urandom());
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    cycle_end();
    for (int n = 0; n < 100 && ack_log.size() < 4; n++) step();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    drain();
    check_eq("tie_ack_count", 32'(ack_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check_eq($sformatf("tie_order%0d", i), 32'(ack_log[i]), 32'(i % 2));
    end

    // Address changed on the master one cycle after grant must not reach the port.
    cycle_begin();
    start_req(0, 1'b1, 12'h001, $urandom());
    cycle_end();
    cycle_begin();
    addr[0] = 12'h002;
    #1;
    check_eq("chg_strobe", 32'(reg_wr_en), 32'd1);
    check_eq("chg_addr", 32'(reg_wr_addr), 32'h001);
    cycle_end();
    drain();

    // Reset during the read wait: no ack afterwards, late read data ignored.
    ack_log.delete();
    cycle_begin();
    start_req(1, 1'b0, AW'($urandom()), $urandom());
    cycle_end();
    step();
    cycle_begin();
    ghost_cyc = t_g + 1 + int'(LAT);
    ghost_val = 32'hA5A5_0F0F;
    pulse_reset();
    repeat (10) step();
    check_eq("rwait_no_ack", 32'(ack_log.size()), 32'd0);
    check_eq("rwait_rdata1", m1_rdata, 32'd0);
    ghost_cyc = -1;

    // Early request drop during the strobe cycle still completes.
    ack_log.delete();
    cycle_begin();
    start_req(1, 1'b1, AW'($urandom()), $urandom());
    cycle_end();
    cycle_begin();
    req[1] = 1'b0;
    cycle_end();
    drain();
    check_eq("drop_ack_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) check_eq("drop_ack_who", 32'(ack_log[0]), 32'd1);

    // Random traffic with occasional resets during a read wait.
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      cycle_begin();
      if (act && !t_we && cyc > t_g + 1 && cyc < t_ack && $urandom_range(24) == 0) begin
        pulse_reset();
      end else begin
        drive_random();
        cycle_end();
      end
    end
    rand_mode = 1'b0;
    hold[0]   = 1'b0;
    hold[1]   = 1'b0;
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
